// File: rtl/cpe_seq_pkg.sv
// Shared types and constants for the CPE job sequencer and its watchdog.
package cpe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  localparam int JOB_COUNT_WIDTH = 16;

  // Wide enough to hold the count value TIMEOUT_CYCLES itself.
  function automatic int watchdogWidth(input int timeoutCycles);
    return $clog2(timeoutCycles + 1);
  endfunction

endpackage

// File: rtl/cpe_seq_watchdog.sv
// Clear/enable up-counter that flags the enabled cycle on which the count
// reaches TIMEOUT_CYCLES; it saturates there so a long stall cannot wrap.
module cpe_seq_watchdog
  import cpe_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = watchdogWidth(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != MAX_COUNT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // The current enabled cycle is the TIMEOUT_CYCLES-th one since the clear.
  assign expired_o = enable_i && (count_q >= LAST_COUNT);

endmodule

// File: rtl/cpe_job_sequencer.sv
// Control FSM feeding one matrixAccelerator: latches a job, pulses mStart,
// waits for finalReady under a watchdog and hands back the result.
module cpe_job_sequencer
  import cpe_seq_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int AXI_BUS_WIDTH  = 32,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                            Clk,
  input  logic                                            Rst,
  input  logic                                            job_valid,
  output logic                                            job_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0] job_multiplier,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0] job_multiplicand,
  input  logic                                            job_relu,
  input  logic [TAG_WIDTH-1:0]                            job_tag,
  output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0] multiplier_input,
  output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0] multiplicand_input,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]              mStart,
  output logic                                            lin_mux,
  input  logic [AXI_BUS_WIDTH-1:0]                        finalAccumulate,
  input  logic                                            finalReady,
  output logic                                            res_valid,
  input  logic                                            res_ready,
  output logic [AXI_BUS_WIDTH-1:0]                        res_data,
  output logic [TAG_WIDTH-1:0]                            res_tag,
  output logic                                            res_error,
  output logic                                            busy,
  output logic [JOB_COUNT_WIDTH-1:0]                      job_count
);

  localparam int LANES    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int BUS_BITS = LANES * AXI_BUS_WIDTH;

  seq_state_e                 state_q;
  logic [BUS_BITS-1:0]        multiplier_q;
  logic [BUS_BITS-1:0]        multiplicand_q;
  logic [LANES-1:0]           mStart_q;
  logic                       linMux_q;
  logic [AXI_BUS_WIDTH-1:0]   resData_q;
  logic [TAG_WIDTH-1:0]       resTag_q;
  logic                       resError_q;
  logic [JOB_COUNT_WIDTH-1:0] jobCount_q;

  logic wdClear;
  logic wdEnable;
  logic wdExpired;

  assign wdClear  = (state_q == ISSUE);
  assign wdEnable = (state_q == WAIT);

  cpe_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clk      (Clk),
    .Rst      (Rst),
    .clear_i  (wdClear),
    .enable_i (wdEnable),
    .expired_o(wdExpired)
  );

  // finalReady is only looked at in WAIT, which starts after the ISSUE
  // pulse, so a level left over from an earlier job cannot complete this one.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q        <= IDLE;
      multiplier_q   <= '0;
      multiplicand_q <= '0;
      mStart_q       <= '0;
      linMux_q       <= 1'b1;
      resData_q      <= '0;
      resTag_q       <= '0;
      resError_q     <= 1'b0;
      jobCount_q     <= '0;
    end else begin
      mStart_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (job_valid) begin
            multiplier_q   <= job_multiplier;
            multiplicand_q <= job_multiplicand;
            linMux_q       <= ~job_relu;
            resTag_q       <= job_tag;
            mStart_q       <= '1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (finalReady) begin
            resData_q  <= finalAccumulate;
            resError_q <= 1'b0;
            state_q    <= HOLD;
          end else if (wdExpired) begin
            resData_q  <= '0;
            resError_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            jobCount_q <= jobCount_q + JOB_COUNT_WIDTH'(1);
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign job_ready          = (state_q == IDLE);
  assign res_valid          = (state_q == HOLD);
  assign busy               = (state_q != IDLE);
  assign multiplier_input   = multiplier_q;
  assign multiplicand_input = multiplicand_q;
  assign mStart             = mStart_q;
  assign lin_mux            = linMux_q;
  assign res_data           = resData_q;
  assign res_tag            = resTag_q;
  assign res_error          = resError_q;
  assign job_count          = jobCount_q;

endmodule

// File: tb/tb_cpe_job_sequencer.sv
// Directed bench for cpe_job_sequencer with a behavioural accelerator and a
// scoreboard of expected results.
module tb_cpe_job_sequencer;

  localparam int KS   = 3;
  localparam int W    = 32;
  localparam int TW   = 4;
  localparam int TO   = 64;
  localparam int N    = KS * KS;
  localparam int BUSW = N * W;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            job_valid;
  logic            job_ready;
  logic [BUSW-1:0] job_multiplier;
  logic [BUSW-1:0] job_multiplicand;
  logic            job_relu;
  logic [TW-1:0]   job_tag;
  logic [BUSW-1:0] multiplier_input;
  logic [BUSW-1:0] multiplicand_input;
  logic [N-1:0]    mStart;
  logic            lin_mux;
  logic [W-1:0]    finalAccumulate;
  logic            finalReady;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;
  logic [TW-1:0]   res_tag;
  logic            res_error;
  logic            busy;
  logic [15:0]     job_count;

  always #5 Clk = ~Clk;

  cpe_job_sequencer #(
    .KERNEL_SIZE   (KS),
    .AXI_BUS_WIDTH (W),
    .TAG_WIDTH     (TW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_multiplier    (job_multiplier),
    .job_multiplicand  (job_multiplicand),
    .job_relu          (job_relu),
    .job_tag           (job_tag),
    .multiplier_input  (multiplier_input),
    .multiplicand_input(multiplicand_input),
    .mStart            (mStart),
    .lin_mux           (lin_mux),
    .finalAccumulate   (finalAccumulate),
    .finalReady        (finalReady),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .res_tag           (res_tag),
    .res_error         (res_error),
    .busy              (busy),
    .job_count         (job_count)
  );

  // Behavioural accelerator: sums lane products of the driven buses and
  // raises finalReady for one cycle modelLatency edges after the mStart pulse.
  logic         modelEnable;
  int           modelLatency;
  int           modelCnt    = 0;
  logic         modelReady  = 1'b0;
  logic [W-1:0] modelSum    = '0;
  logic [W-1:0] modelAccum  = '0;
  logic         forceReady;
  logic [W-1:0] forceAccum;

  assign finalReady      = modelReady | forceReady;
  assign finalAccumulate = forceReady ? forceAccum : modelAccum;

  function automatic logic [W-1:0] laneSum(input logic [BUSW-1:0] a, input logic [BUSW-1:0] b);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + a[i*W +: W] * b[i*W +: W];
    return s;
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      modelCnt   <= 0;
      modelReady <= 1'b0;
    end else begin
      modelReady <= 1'b0;
      if (modelEnable && (mStart == {N{1'b1}})) begin
        modelCnt <= modelLatency;
        modelSum <= laneSum(multiplier_input, multiplicand_input);
      end else if (modelCnt != 0) begin
        modelCnt <= modelCnt - 1;
        if (modelCnt == 1) begin
          modelReady <= 1'b1;
          modelAccum <= (lin_mux || !modelSum[W-1]) ? modelSum : '0;
        end
      end
    end
  end

  typedef struct packed {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] expCount;

  task automatic checkOutput(input string name, input logic [BUSW-1:0] observed,
                             input logic [BUSW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  function automatic logic [BUSW-1:0] fillLanes(input logic [W-1:0] v);
    logic [BUSW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  task automatic checkResetValues();
    checkOutput("rstJobReady", job_ready, 1'b1);
    checkOutput("rstMStart", mStart, '0);
    checkOutput("rstMultiplier", multiplier_input, '0);
    checkOutput("rstMultiplicand", multiplicand_input, '0);
    checkOutput("rstLinMux", lin_mux, 1'b1);
    checkOutput("rstResValid", res_valid, 1'b0);
    checkOutput("rstResData", res_data, '0);
    checkOutput("rstResTag", res_tag, '0);
    checkOutput("rstResError", res_error, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstJobCount", job_count, '0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first WAIT cycle.
  task automatic applyStimulus(input logic [BUSW-1:0] aBus, input logic [BUSW-1:0] bBus,
                               input logic relu, input logic [TW-1:0] tag,
                               input logic [W-1:0] expData, input logic expErr);
    logic expMux;
    exp_t e;
    expMux = ~relu;
    checkOutput("jobReadyIdle", job_ready, 1'b1);
    job_multiplier   = aBus;
    job_multiplicand = bBus;
    job_relu         = relu;
    job_tag          = tag;
    job_valid        = 1'b1;
    e.data = expData;
    e.tag  = tag;
    e.err  = expErr;
    sbQ.push_back(e);
    @(negedge Clk);
    job_valid        = 1'b0;
    job_multiplier   = ~aBus;
    job_multiplicand = ~bBus;
    job_relu         = ~relu;
    checkOutput("mStartIssue", mStart, {N{1'b1}});
    checkOutput("busyIssue", busy, 1'b1);
    checkOutput("jobReadyIssue", job_ready, 1'b0);
    checkOutput("linMuxIssue", lin_mux, expMux);
    checkOutput("multiplierIssue", multiplier_input, aBus);
    checkOutput("multiplicandIssue", multiplicand_input, bBus);
    @(negedge Clk);
    checkOutput("mStartWait", mStart, '0);
    checkOutput("multiplierHeld", multiplier_input, aBus);
    checkOutput("linMuxHeld", lin_mux, expMux);
  endtask

  task automatic collectResult(input int budget, input int bp, output int lat);
    exp_t e;
    lat = 0;
    while ((res_valid !== 1'b1) && (lat < budget)) begin
      @(negedge Clk);
      lat++;
    end
    checkOutput("resValidSeen", res_valid, 1'b1);
    if (res_valid !== 1'b1 || sbQ.size() == 0) return;
    e = sbQ.pop_front();
    for (int i = 0; i <= bp; i++) begin
      if (i > 0) @(negedge Clk);
      checkOutput("resValidHold", res_valid, 1'b1);
      checkOutput("resData", res_data, e.data);
      checkOutput("resTag", res_tag, e.tag);
      checkOutput("resError", res_error, e.err);
      checkOutput("jobReadyHold", job_ready, 1'b0);
      checkOutput("jobCountHold", job_count, expCount);
    end
    res_ready = 1'b1;
    @(negedge Clk);
    res_ready = 1'b0;
    expCount  = expCount + 16'd1;
    checkOutput("resValidDone", res_valid, 1'b0);
    checkOutput("jobCountDone", job_count, expCount);
    checkOutput("jobReadyDone", job_ready, 1'b1);
  endtask

  initial begin
    logic [BUSW-1:0] aBus;
    logic [BUSW-1:0] bBus;
    int lat;
    int sz;
    Rst = 1'b1;
    job_valid = 1'b0;
    job_multiplier = '0;
    job_multiplicand = '0;
    job_relu = 1'b0;
    job_tag = '0;
    res_ready = 1'b0;
    modelEnable = 1'b1;
    modelLatency = 2;
    forceReady = 1'b0;
    forceAccum = '0;
    expCount = '0;
    repeat (3) @(negedge Clk);
    checkResetValues();
    Rst = 1'b0;
    @(negedge Clk);
    checkResetValues();

    $display("[TB] linear job");
    applyStimulus(fillLanes(32'd2), fillLanes(32'd3), 1'b0, 4'd5, 32'd54, 1'b0);
    collectResult(20, 0, lat);

    $display("[TB] relu jobs and backpressure");
    applyStimulus(fillLanes(32'hFFFFFFFE), fillLanes(32'd3), 1'b1, 4'd6, 32'd0, 1'b0);
    collectResult(20, 0, lat);
    applyStimulus(fillLanes(32'hFFFFFFFE), fillLanes(32'd3), 1'b0, 4'd7, 32'hFFFFFFCA, 1'b0);
    collectResult(20, 10, lat);

    $display("[TB] watchdog timeout");
    modelEnable = 1'b0;
    applyStimulus(fillLanes(32'd1), fillLanes(32'd1), 1'b0, 4'd8, 32'd0, 1'b1);
    collectResult(100, 0, lat);
    checkOutput("timeoutLatency", lat, TO);

    $display("[TB] finalReady on the timeout cycle");
    applyStimulus(fillLanes(32'd1), fillLanes(32'd1), 1'b0, 4'd9, 32'h12345678, 1'b0);
    repeat (TO - 1) @(negedge Clk);
    checkOutput("noEarlyTimeout", res_valid, 1'b0);
    forceAccum = 32'h12345678;
    forceReady = 1'b1;
    collectResult(2, 0, lat);
    forceReady = 1'b0;
    checkOutput("raceLatency", lat, 1);

    $display("[TB] stale finalReady");
    modelEnable = 1'b1;
    modelLatency = 3;
    forceAccum = 32'hDEADBEEF;
    forceReady = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      checkOutput("noValidIdle", res_valid, 1'b0);
    end
    applyStimulus(fillLanes(32'd4), fillLanes(32'hFFFFFFFF), 1'b0, 4'hA, 32'hFFFFFFDC, 1'b0);
    forceReady = 1'b0;
    checkOutput("noCaptureBeforeWait", res_valid, 1'b0);
    collectResult(20, 0, lat);

    $display("[TB] distinct lanes");
    modelLatency = 1;
    for (int i = 0; i < N; i++) begin
      aBus[i*W +: W] = 32'(i + 1);
      bBus[i*W +: W] = 32'(10 * (i + 1));
    end
    applyStimulus(aBus, bBus, 1'b1, 4'hB, 32'd2850, 1'b0);
    collectResult(20, 0, lat);

    $display("[TB] reset during WAIT");
    modelEnable = 1'b0;
    applyStimulus(fillLanes(32'd7), fillLanes(32'd7), 1'b1, 4'hC, 32'd0, 1'b1);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    #1;
    void'(sbQ.pop_back());
    expCount = '0;
    checkResetValues();
    @(negedge Clk);
    Rst = 1'b0;
    modelEnable = 1'b1;
    modelLatency = 2;
    @(negedge Clk);
    applyStimulus(fillLanes(32'd5), fillLanes(32'hFFFFFFFD), 1'b0, 4'hD, 32'hFFFFFF79, 1'b0);
    collectResult(20, 0, lat);

    sz = sbQ.size();
    checkOutput("scoreboardEmpty", sz, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
